// File: rtl/rr_sel_arbiter_pkg.sv
// Shared defaults and state encoding for the round-robin select arbiter.
// The select feeds the downstream 4:1 mux; sel[0] also drives the 2:1 mux and 1:2 demux.
package rr_sel_arbiter_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int SEL_W_DEF    = 2;
  localparam int HOLD_MAX_DEF = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Request/select bundle between the requesters and the arbiter.
// The port for the owner's release is named owner_release because "release" is a language keyword.
interface rr_sel_arbiter_if
  import rr_sel_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = SEL_W_DEF
);

  logic [N_REQ-1:0] req;
  logic             owner_release;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] grant;
  logic             sel_valid;
  logic             timeout;

  modport master (
    output req, owner_release,
    input  sel, grant, sel_valid, timeout
  );

  modport slave (
    input  req, owner_release,
    output sel, grant, sel_valid, timeout
  );

endinterface

// File: rtl/rr_sel_arbiter_pick.sv
// Rotate-priority encoder: finds the first set request at or after ptr, wrapping modulo N_REQ.
module rr_pick
  import rr_sel_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest hit to ptr is the one kept.
  always_comb begin
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = {SEL_W{1'b0}};
    cand  = {SEL_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing a registered binary select and one-hot grant.
// A grant is held until release, request drop or HOLD_MAX cycles, whichever comes first.
module rr_sel_arbiter
  import rr_sel_arbiter_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  rr_sel_arbiter_if.slave  bus
);

  localparam int HOLD_W = $clog2(HOLD_MAX);
  localparam logic [SEL_W-1:0]  SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [N_REQ-1:0]  GNT_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  logic [0:0]        state_r, state_s;
  logic [SEL_W-1:0]  sel_r, sel_s;
  logic [SEL_W-1:0]  ptr_r, ptr_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [N_REQ-1:0]  grant_r, grant_s;
  logic              sel_valid_r, sel_valid_s;
  logic              timeout_r, timeout_s;

  logic              pick_found_s;
  logic [SEL_W-1:0]  pick_idx_s;
  logic              end_rel_s, end_drop_s, end_hold_s, grant_end_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  assign end_rel_s   = bus.owner_release;
  assign end_drop_s  = ~bus.req[sel_r];
  assign end_hold_s  = (hold_cnt_r == HOLD_LAST);
  assign grant_end_s = end_rel_s | end_drop_s | end_hold_s;

  // Next-state logic. ptr already points past the last owner, so a lone
  // requester whose grant ended by release or hold limit is found again.
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    ptr_s       = ptr_r;
    hold_cnt_s  = hold_cnt_r;
    sel_valid_s = sel_valid_r;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_s     = ST_GRANT;
          sel_s       = pick_idx_s;
          ptr_s       = pick_idx_s + SEL_ONE;
          hold_cnt_s  = {HOLD_W{1'b0}};
          sel_valid_s = 1'b1;
        end else begin
          sel_valid_s = 1'b0;
        end
      end
      ST_GRANT: begin
        if (grant_end_s) begin
          timeout_s = end_hold_s & ~end_rel_s & ~end_drop_s;
          if (pick_found_s) begin
            sel_s       = pick_idx_s;
            ptr_s       = pick_idx_s + SEL_ONE;
            hold_cnt_s  = {HOLD_W{1'b0}};
            sel_valid_s = 1'b1;
          end else begin
            state_s     = ST_IDLE;
            hold_cnt_s  = {HOLD_W{1'b0}};
            sel_valid_s = 1'b0;
          end
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        hold_cnt_s  = {HOLD_W{1'b0}};
        sel_valid_s = 1'b0;
      end
    endcase
    grant_s = sel_valid_s ? (GNT_ONE << sel_s) : {N_REQ{1'b0}};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      sel_r       <= {SEL_W{1'b0}};
      ptr_r       <= {SEL_W{1'b0}};
      hold_cnt_r  <= {HOLD_W{1'b0}};
      grant_r     <= {N_REQ{1'b0}};
      sel_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      sel_r       <= sel_s;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= hold_cnt_s;
      grant_r     <= grant_s;
      sel_valid_r <= sel_valid_s;
      timeout_r   <= timeout_s;
    end
  end

  assign bus.sel       = sel_r;
  assign bus.grant     = grant_r;
  assign bus.sel_valid = sel_valid_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter: a vector table for reset, rotation, drop and
// mid-grant reset, plus hand sequences for the hold-limit timeout cases.
module tb_rr_sel_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rr_sel_arbiter_if #(.N_REQ(4), .SEL_W(2)) bus ();

  rr_sel_arbiter #(.N_REQ(4), .SEL_W(2), .HOLD_MAX(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       tmo;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic rl);
    @(negedge clk);
    rst               = r;
    bus.req           = q;
    bus.owner_release = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [1:0] s, input logic [3:0] g, input logic v, input logic t);
    check("sel", idx, 32'(bus.sel), 32'(s));
    check("grant", idx, 32'(bus.grant), 32'(g));
    check("sel_valid", idx, 32'(bus.sel_valid), 32'(v));
    check("timeout", idx, 32'(bus.timeout), 32'(t));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst               = 1'b1;
    bus.req           = 4'b0000;
    bus.owner_release = 1'b0;

    // reset, then idle with no requests
    vecs[0]  = '{1'b1, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0};
    for (int i = 1; i <= 5; i++) vecs[i] = '{1'b0, 4'h0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0};
    // all requesting, release every 3rd cycle: 0,1,2,3,0 back-to-back
    vecs[6]  = '{1'b0, 4'hF, 1'b0, 2'd0, 4'h1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'hF, 1'b0, 2'd0, 4'h1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'hF, 1'b1, 2'd1, 4'h2, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'hF, 1'b0, 2'd1, 4'h2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'hF, 1'b0, 2'd1, 4'h2, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'hF, 1'b1, 2'd2, 4'h4, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'hF, 1'b0, 2'd2, 4'h4, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 4'hF, 1'b0, 2'd2, 4'h4, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 4'hF, 1'b1, 2'd3, 4'h8, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 4'hF, 1'b0, 2'd3, 4'h8, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'hF, 1'b0, 2'd3, 4'h8, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 4'hF, 1'b1, 2'd0, 4'h1, 1'b1, 1'b0};
    // owner 1 with req=0011, then drop req[1]: wrap to 0
    vecs[18] = '{1'b0, 4'h3, 1'b1, 2'd1, 4'h2, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 4'h3, 1'b0, 2'd1, 4'h2, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 4'h1, 1'b0, 2'd0, 4'h1, 1'b1, 1'b0};
    // owner 3 up to hold_cnt=4, reset, then re-request
    vecs[21] = '{1'b0, 4'h8, 1'b0, 2'd3, 4'h8, 1'b1, 1'b0};
    for (int i = 22; i <= 25; i++) vecs[i] = '{1'b0, 4'h8, 1'b0, 2'd3, 4'h8, 1'b1, 1'b0};
    vecs[26] = '{1'b1, 4'h8, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 4'h8, 1'b0, 2'd3, 4'h8, 1'b1, 1'b0};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].rel);
      check_all(i, vecs[i].sel, vecs[i].grant, vecs[i].valid, vecs[i].tmo);
    end

    // lone requester 2: 8 granted cycles, then a single timeout pulse with re-grant
    step(1'b1, 4'h0, 1'b0);
    check_all(100, 2'd0, 4'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 4'h4, 1'b0);
      check_all(100 + k, 2'd2, 4'h4, 1'b1, 1'b0);
    end
    step(1'b0, 4'h4, 1'b0);
    check_all(109, 2'd2, 4'h4, 1'b1, 1'b1);
    // hold restarted: 7 more plain cycles, last reaching hold_cnt=7
    for (int k = 10; k <= 16; k++) begin
      step(1'b0, 4'h4, 1'b0);
      check_all(100 + k, 2'd2, 4'h4, 1'b1, 1'b0);
    end
    // release coincides with the hold limit: normal end, no timeout
    step(1'b0, 4'h4, 1'b1);
    check_all(117, 2'd2, 4'h4, 1'b1, 1'b0);
    // request drop coincides with nothing else pending: back to idle
    step(1'b0, 4'h0, 1'b0);
    check_all(118, 2'd2, 4'h0, 1'b0, 1'b0);

    // new request during a grant does not pre-empt the owner
    step(1'b0, 4'h1, 1'b0);
    check_all(119, 2'd0, 4'h1, 1'b1, 1'b0);
    step(1'b0, 4'h3, 1'b0);
    check_all(120, 2'd0, 4'h1, 1'b1, 1'b0);
    step(1'b0, 4'h3, 1'b1);
    check_all(121, 2'd1, 4'h2, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
